vd_scheduler: RTL and testbench

Job scheduler and RAM-port owner for the vector divider engine. Host commands (pair counts) are queued in a small FIFO. The block launches the engine once per command via startvd/busyvd and counts completions. It muxes the single-port RAM between the host loader and the engine, so the host can load operands and read results while the engine is idle.

---
 rtl/vd_sched_pkg.sv | 28 ++
 rtl/vd_cmd_fifo.sv | 55 +++++
 rtl/vd_scheduler.sv | 163 ++++++++++++++++
 tb/tb_vd_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vd_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vd_sched_pkg
// Purpose  : Shared types and constants for the vector divider scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package vd_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4,
    SKIP      = 3'd5
  } vd_state_t;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int DONE_CNT_W     = 16;
  localparam int TIMER_W        = 8;

  // The engine holds the RAM port from the start pulse until busy falls.
  function automatic logic engine_owns_ram(input vd_state_t state);
    return (state == LAUNCH) || (state == WAIT_BUSY) || (state == RUN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vd_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vd_cmd_fifo
// Purpose  : Synchronous command FIFO with full/empty flags and same-cycle
//            push/pop. Head is presented combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module vd_cmd_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int              c_depth   = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_ptr_one = 1;

  logic [WIDTH-1:0]    r_mem [c_depth];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_push;
  logic                w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                 (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/vd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vd_scheduler
// Purpose  : Queues host jobs, launches the vector divider once per job and
//            arbitrates the single-port RAM between host and engine.
//            Build with VD_SCHED_TIMEOUT_EN for the WAIT_BUSY timeout / err.
// Revision : 1.0 - initial release
// ============================================================================
module vd_scheduler
  import vd_sched_pkg::*;
#(
  parameter int RAM_SIZE    = 10,
  parameter int NBITS       = 32,
  parameter int QDEPTH_LOG2 = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [RAM_SIZE-1:0]   host_addr,
  input  logic [NBITS-1:0]      host_wdata,
  output logic                  host_gnt,
  output logic [NBITS-1:0]      host_rdata,
  input  logic                  cmd_valid,
  input  logic [RAM_SIZE-1:0]   cmd_ndata,
  output logic                  cmd_ready,
  output logic [RAM_SIZE-1:0]   vd_ndata,
  output logic                  vd_startvd,
  input  logic                  vd_busyvd,
  input  logic [RAM_SIZE-1:0]   vd_addr,
  input  logic [NBITS-1:0]      vd_wdata,
  input  logic                  vd_wenable,
  output logic [NBITS-1:0]      vd_rdata,
  output logic [RAM_SIZE-1:0]   ram_addr,
  output logic [NBITS-1:0]      ram_wdata,
  output logic                  ram_wenable,
  input  logic [NBITS-1:0]      ram_rdata,
  output logic [DONE_CNT_W-1:0] done_count,
  output logic                  irq,
  output logic                  idle,
  output logic                  err
);

  localparam logic [DONE_CNT_W-1:0] c_done_one = 1;

  vd_state_t             r_state;
  logic [RAM_SIZE-1:0]   r_ndata;
  logic                  r_startvd;
  logic                  r_irq;
  logic [DONE_CNT_W-1:0] r_done_count;

  logic [RAM_SIZE-1:0]   w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_timeout;
  logic                  w_engine_owns;

  vd_cmd_fifo #(
    .WIDTH      (RAM_SIZE),
    .DEPTH_LOG2 (QDEPTH_LOG2)
  ) u_cmd_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cmd_valid),
    .pop   (w_pop),
    .wdata (cmd_ndata),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // A timed-out job leaves the queue exactly like a completed one.
  assign w_pop = (r_state == DONE) || (r_state == SKIP) || w_timeout;

`ifdef VD_SCHED_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] c_timer_last = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_timer_one  = 1;

  logic [TIMER_W-1:0] r_timer;
  logic               r_err;

  assign w_timeout = (r_state == WAIT_BUSY) && !vd_busyvd && (r_timer == c_timer_last);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state != WAIT_BUSY) r_timer <= '0;
      else if (!vd_busyvd)      r_timer <= r_timer + c_timer_one;
      if (w_timeout)            r_err   <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_ndata      <= '0;
      r_startvd    <= 1'b0;
      r_irq        <= 1'b0;
      r_done_count <= '0;
    end else begin
      r_startvd <= 1'b0;
      r_irq     <= 1'b0;
      case (r_state)
        IDLE: begin
          // Host access always wins; a queued job waits until req drops.
          if (!host_req && !w_empty) begin
            if (w_head == '0) begin
              r_state <= SKIP;
              r_irq   <= 1'b1;
            end else begin
              r_ndata   <= w_head;
              r_startvd <= 1'b1;
              r_state   <= LAUNCH;
            end
          end
        end
        LAUNCH: r_state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (vd_busyvd)      r_state <= RUN;
          else if (w_timeout) r_state <= IDLE;
        end
        RUN: begin
          if (!vd_busyvd) begin
            r_state <= DONE;
            r_irq   <= 1'b1;
          end
        end
        DONE, SKIP: begin
          r_done_count <= r_done_count + c_done_one;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_engine_owns = engine_owns_ram(r_state);

  assign host_gnt    = host_req && (r_state == IDLE);
  assign ram_addr    = w_engine_owns ? vd_addr    : host_addr;
  assign ram_wdata   = w_engine_owns ? vd_wdata   : host_wdata;
  assign ram_wenable = w_engine_owns ? vd_wenable : (host_gnt && host_we);
  assign vd_rdata    = ram_rdata;
  assign host_rdata  = ram_rdata;

  assign cmd_ready  = !w_full;
  assign idle       = (r_state == IDLE) && w_empty;
  assign vd_ndata   = r_ndata;
  assign vd_startvd = r_startvd;
  assign irq        = r_irq;
  assign done_count = r_done_count;

endmodule
`default_nettype wire

// File: tb/tb_vd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vd_scheduler
// Purpose  : Self-checking bench for vd_scheduler: phase/queue reference model,
//            bench RAM and engine, directed scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vd_scheduler;

  localparam int QDEPTH  = 4;
  localparam int P_IDLE  = 0;
  localparam int P_LAUNCH = 1;
  localparam int P_WAIT  = 2;
  localparam int P_RUN   = 3;
  localparam int P_DONE  = 4;
  localparam int P_SKIP  = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [9:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_gnt;
  logic [31:0] host_rdata;
  logic        cmd_valid = 1'b0;
  logic [9:0]  cmd_ndata = '0;
  logic        cmd_ready;
  logic [9:0]  vd_ndata;
  logic        vd_startvd;
  logic        vd_busyvd;
  logic [9:0]  vd_addr;
  logic [31:0] vd_wdata;
  logic        vd_wenable;
  logic [31:0] vd_rdata;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wenable;
  logic [31:0] ram_rdata;
  logic [15:0] done_count;
  logic        irq, idle, err;

  vd_scheduler #(.RAM_SIZE(10), .NBITS(32), .QDEPTH_LOG2(2)) dut (
    .clock(clock), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata),
    .cmd_valid(cmd_valid), .cmd_ndata(cmd_ndata), .cmd_ready(cmd_ready),
    .vd_ndata(vd_ndata), .vd_startvd(vd_startvd), .vd_busyvd(vd_busyvd),
    .vd_addr(vd_addr), .vd_wdata(vd_wdata), .vd_wenable(vd_wenable), .vd_rdata(vd_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wenable(ram_wenable), .ram_rdata(ram_rdata),
    .done_count(done_count), .irq(irq), .idle(idle), .err(err)
  );

  always #5 clock = ~clock;

  // Synchronous single-port RAM, read-first, one cycle latency.
  logic [31:0] ram_mem [1024];
  always @(posedge clock) begin
    if (ram_wenable) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_irq    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          ph = P_IDLE;
  int          q[$];
  logic [9:0]  m_ndata = '0;
  logic [15:0] m_done = '0;
  bit          m_err = 1'b0;
  int          m_wait = 0;
  bit          m_rd_pend = 1'b0;
  logic [31:0] m_rd_exp = '0;
  logic [31:0] ref_mem [1024];
  bit          ref_valid [1024];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph = P_IDLE; q.delete(); m_ndata = '0; m_done = '0; m_err = 1'b0;
      m_wait = 0; m_rd_pend = 1'b0;
    end else begin
      bit push, pop, eng, gnt;
      int np;
      push = cmd_valid && (q.size() < QDEPTH);
      pop  = 1'b0;
      np   = ph;
      eng  = (ph == P_LAUNCH) || (ph == P_WAIT) || (ph == P_RUN);
      gnt  = (ph == P_IDLE) && host_req;
      m_rd_pend = gnt && !host_we && ref_valid[host_addr];
      m_rd_exp  = ref_mem[host_addr];
      if (gnt && host_we) begin ref_mem[host_addr] = host_wdata; ref_valid[host_addr] = 1'b1; end
      if (eng && vd_wenable) begin ref_mem[vd_addr] = vd_wdata; ref_valid[vd_addr] = 1'b1; end
      case (ph)
        P_IDLE: if (!host_req && q.size() > 0) begin
          if (q[0] == 0) np = P_SKIP;
          else begin m_ndata = 10'(q[0]); np = P_LAUNCH; end
        end
        P_LAUNCH: begin np = P_WAIT; m_wait = 0; end
        P_WAIT: if (vd_busyvd) np = P_RUN;
`ifdef VD_SCHED_TIMEOUT_EN
          else begin
            m_wait++;
            if (m_wait == 16) begin m_err = 1'b1; pop = 1'b1; np = P_IDLE; end
          end
`endif
        P_RUN: if (!vd_busyvd) np = P_DONE;
        default: begin pop = 1'b1; m_done = m_done + 16'd1; np = P_IDLE; end
      endcase
      if (pop) void'(q.pop_front());
      if (push) q.push_back(int'(cmd_ndata));
      ph = np;
    end
  end

  bit cmp_eng;
  always @(negedge clock) begin
    if (reset) begin
      if (vd_startvd) n_start++;
      if (irq) n_irq++;
    end
    if (reset && chk_en) begin
      cmp_eng = (ph == P_LAUNCH) || (ph == P_WAIT) || (ph == P_RUN);
      chk("vd_startvd", vd_startvd, ph == P_LAUNCH);
      chk("irq", irq, (ph == P_DONE) || (ph == P_SKIP));
      chk("idle", idle, (ph == P_IDLE) && (q.size() == 0));
      chk("cmd_ready", cmd_ready, q.size() < QDEPTH);
      chk("done_count", done_count, m_done);
      chk("vd_ndata", vd_ndata, m_ndata);
      chk("err", err, m_err);
      chk("host_gnt", host_gnt, (ph == P_IDLE) && host_req);
      chk("ram_addr", ram_addr, cmp_eng ? vd_addr : host_addr);
      chk("ram_wdata", ram_wdata, cmp_eng ? vd_wdata : host_wdata);
      chk("ram_wenable", ram_wenable, cmp_eng ? vd_wenable : ((ph == P_IDLE) && host_req && host_we));
      chk("vd_rdata", vd_rdata, ram_rdata);
      chk("host_rdata", host_rdata, ram_rdata);
      if (m_rd_pend) chk("host_read_value", host_rdata, m_rd_exp);
    end
  end

  // ---------------- engine model ----------------
  int e_wait = 0, e_left = 0, eng_fixed = 0;
  bit eng_en = 1'b1;

  task automatic eng_drive();
    vd_addr    = 10'($urandom);
    vd_wdata   = $urandom;
    vd_wenable = $urandom_range(0, 1) == 1;
  endtask

  initial begin
    vd_busyvd = 1'b0; vd_addr = '0; vd_wdata = '0; vd_wenable = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (!reset) begin
        e_wait = 0; e_left = 0; vd_busyvd = 1'b0; vd_wenable = 1'b0;
      end else if (e_left > 0) begin
        e_left--;
        if (e_left == 0) begin vd_busyvd = 1'b0; vd_wenable = 1'b0; end
        else eng_drive();
      end else if (e_wait > 0) begin
        e_wait--;
        if (e_wait == 0) begin
          vd_busyvd = 1'b1;
          e_left = (eng_fixed > 0) ? eng_fixed : int'($urandom_range(1, 12));
          eng_drive();
        end
      end else if (vd_startvd && eng_en) begin
        e_wait = (eng_fixed > 0) ? 1 : 1 + int'($urandom_range(0, 2));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic push(input logic [9:0] v);
    cmd_valid = 1'b1; cmd_ndata = v;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (!idle && n < max);
    chk("wait_idle", idle, 1);
  endtask

  task automatic wait_busy(input int max);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (!vd_busyvd && n < max);
    chk("wait_busy", vd_busyvd, 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_startvd"}, vd_startvd, 0);
    chk({tag, "_ndata"}, vd_ndata, 0);
    chk({tag, "_done"}, done_count, 0);
    chk({tag, "_irq"}, irq, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ram_we"}, ram_wenable, 0);
    chk({tag, "_idle"}, idle, 1);
    chk({tag, "_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  int b_start, b_irq, cyc;

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_reset_values("reset");
    tick();
    reset = 1'b1;
    chk_en = 1'b1;

    // Host load and readback with the engine idle.
    for (int i = 0; i < 10; i++) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = 10'(i); host_wdata = 32'hA5A5_0000 | i;
      @(negedge clock);
      chk("t1_gnt", host_gnt, 1);
      chk("t1_we", ram_wenable, 1);
      tick();
    end
    host_we = 1'b0; host_addr = 10'd3;
    @(negedge clock);
    chk("t1_rd_we", ram_wenable, 0);
    tick();
    host_req = 1'b0;
    @(negedge clock);
    chk("t1_rdata", host_rdata, 32'hA5A5_0003);

    // Single job, busy one cycle after start for 20 cycles.
    eng_fixed = 20; b_start = n_start; b_irq = n_irq;
    tick();
    push(10'd5);
    wait_idle(100);
    chk("t2_starts", n_start - b_start, 1);
    chk("t2_irqs", n_irq - b_irq, 1);
    chk("t2_ndata", vd_ndata, 5);
    chk("t2_done", done_count, 1);

    // Fill the queue while the host stalls launches; zero job is skipped.
    b_start = n_start; b_irq = n_irq;
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'd7;
    push(10'd3); push(10'd0); push(10'd7); push(10'd2);
    cmd_valid = 1'b1; cmd_ndata = 10'd9;
    @(negedge clock);
    chk("t3_ready_full", cmd_ready, 0);
    tick();
    cmd_valid = 1'b0; host_req = 1'b0;
    wait_idle(300);
    chk("t3_done", done_count, 5);
    chk("t3_starts", n_start - b_start, 3);
    chk("t3_irqs", n_irq - b_irq, 4);

    // Host priority in IDLE, engine ownership in RUN.
    eng_fixed = 8; b_start = n_start;
    host_req = 1'b1; host_we = 1'b0;
    push(10'd4);
    repeat (6) tick();
    chk("t4_no_launch", n_start - b_start, 0);
    chk("t4_not_idle", idle, 0);
    host_req = 1'b0;
    @(negedge clock);
    chk("t4_hold", vd_startvd, 0);
    @(negedge clock);
    chk("t4_launch", vd_startvd, 1);
    wait_busy(10);
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h155; host_wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("t4_gnt_run", host_gnt, 0);
    chk("t4_ram_addr_run", ram_addr, vd_addr);
    chk("t4_ram_we_run", ram_wenable, vd_wenable);
    tick();
    host_req = 1'b0; host_we = 1'b0;
    wait_idle(100);
    chk("t4_done", done_count, 6);

    // Asynchronous reset while running with jobs queued.
    host_req = 1'b1;
    push(10'd6); push(10'd7); push(10'd8);
    host_req = 1'b0;
    wait_busy(20);
    @(posedge clock); #3 reset = 1'b0;
    #1 check_reset_values("t5");
    chk("t5_gnt", host_gnt, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    b_start = n_start;
    repeat (10) @(negedge clock);
    chk("t5_no_launch", n_start - b_start, 0);
    chk("t5_done", done_count, 0);
    chk("t5_idle", idle, 1);

    // Random traffic against the model.
    eng_fixed = 0; b_start = n_start;
    tick();
    for (int c = 0; c < 3000; c++) begin
      host_req   = $urandom_range(0, 99) < 30;
      host_we    = $urandom_range(0, 1) == 1;
      host_addr  = 10'($urandom);
      host_wdata = $urandom;
      cmd_valid  = $urandom_range(0, 99) < 15;
      cmd_ndata  = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      tick();
    end
    host_req = 1'b0; host_we = 1'b0; cmd_valid = 1'b0;
    wait_idle(400);
    chk("rand_activity", n_start > b_start, 1);

`ifdef VD_SCHED_TIMEOUT_EN
    // Engine never answers: err after 16 WAIT_BUSY cycles, next job runs.
    eng_en = 1'b0; b_start = n_start; b_irq = n_irq;
    push(10'd4); push(10'd6);
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (!vd_startvd && cyc < 10);
    chk("t6_first_start", vd_startvd, 1);
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (!err && cyc < 40);
    eng_en = 1'b1;
    chk("t6_err_latency", cyc, 17);
    chk("t6_no_irq", n_irq - b_irq, 0);
    wait_idle(100);
    chk("t6_err_sticky", err, 1);
    chk("t6_starts", n_start - b_start, 2);
    chk("t6_irqs", n_irq - b_irq, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
